mic_frame_ring: RTL and testbench
=================================

# mic_frame_ring

Parametrised multi-channel circular sample buffer for the microphone cross-correlation datapath. Accepts interleaved per-channel samples from the capture front end, packs them into frames of CH samples, and holds the most recent 2^ADDR_W − 1 committed frames in a single inferred simple-dual-port block RAM. The correlator reads any channel at any lag relative to the newest committed frame, with fixed two-cycle latency and one read per cycle. This block supersedes the fixed 1024×18 single-channel BRAM wrapper; it adds framing, lag addressing, fill tracking, flush, and sequencing error detection.

## Interface
- DATA_W, 18, sample width in bits
- ADDR_W, 10, log2 of frame slots; visible history is 2^ADDR_W − 1 frames
- CH, 4, channels per frame; must be a power of two ≥ 2
- CH_W, log2(CH), derived, not overridden

- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush of pointers and fill count
- in_valid  in  1  sample present this cycle
- in_ch  in  CH_W  channel index of the sample
- in_data  in  DATA_W  sample value
- frame_tick  out  1  one-cycle pulse when a frame commits
- seq_err  out  1  one-cycle pulse when a sample arrives out of order
- fill  out  ADDR_W  committed frames available, saturating at 2^ADDR_W − 1
- rd_req  in  1  read request
- rd_ch  in  CH_W  channel to read
- rd_lag  in  ADDR_W  lag in frames; 0 = newest committed frame
- rd_valid  out  1  rd_data/rd_miss valid
- rd_data  out  DATA_W  sample read
- rd_miss  out  1  requested lag not in history; rd_data forced to 0

## Operation
- Storage: 2^ADDR_W × CH words of DATA_W; word address = {frame_slot, ch}. RAM contents are not reset or cleared.
- State: wr_slot (ADDR_W), exp_ch (CH_W), fill (ADDR_W). All are 0 on reset and after clr.
- Write path: when in_valid=1 and in_ch==exp_ch, write in_data to {wr_slot, in_ch} and increment exp_ch. If in_ch==CH−1, commit the frame: wr_slot += 1 (wraps modulo 2^ADDR_W), exp_ch → 0, pulse frame_tick, and increment fill unless already 2^ADDR_W − 1.
- Sequencing error: in_valid=1 with in_ch≠exp_ch pulses seq_err and discards the partial frame (wr_slot unchanged).
  - If in_ch==0, the sample is written as channel 0 of a new frame and exp_ch → 1.
  - Otherwise the sample is dropped and exp_ch → 0.
- Partial frames are never visible to reads.
- Read path: on rd_req=1, miss = (rd_lag ≥ fill). Read slot = (wr_slot − 1 − rd_lag) mod 2^ADDR_W, computed from the pre-edge wr_slot and fill.
- Max hit lag is 2^ADDR_W − 2, because the in-progress slot is never readable.
- clr: takes effect at the edge where it is sampled. Any write in that cycle is ignored, and frame_tick/seq_err stay low. Reads already in the pipeline complete with their captured result.

## Timing
- Reset values: frame_tick=0, seq_err=0, fill=0, rd_valid=0, rd_data=0, rd_miss=0.
- Read latency is 2 cycles. rd_req at edge T registers the RAM address and miss flag. RAM data is registered at T+1; rd_data, rd_valid and rd_miss update at T+2.
- Reads are fully pipelined: back-to-back rd_req gives back-to-back rd_valid. rd_valid=0 in cycles with no request two cycles earlier.
- Read and commit in the same cycle: the read sees the pre-commit wr_slot/fill, so the frame committing that cycle is not lag 0 until the next cycle.
- When full, a write to the in-progress slot overwrites the oldest frame. That slot is already excluded by the saturated fill, so reads never return a torn frame.
- frame_tick and seq_err are registered; each pulses in the cycle after the accepting edge.
- fill is registered and updates together with frame_tick.
- rst_n low mid-operation clears all state and outputs immediately; in-flight reads are lost.

## Test plan
- CH=4, ADDR_W=4. Write frames 0..2 (sample = 16·frame + ch). Read ch2 at lag 0 → rd_data=34 two cycles later, rd_miss=0. Read ch1 at lag 2 → 1. fill=3.
- Write 20 frames. fill saturates at 15. Lag 14, ch3 → 16·5+3=83. Lag 15 → rd_miss=1, rd_data=0.
- Send ch 0,1,3 then 0,1,2,3 with values 100..103. seq_err pulses once, no frame_tick for the broken frame. Lag 0, ch3 → 103.
- Send ch 0,1,0,1,2,3. seq_err pulses once and exactly one frame commits. Lag 0, ch0 → the second ch0 value.
- Issue rd_req for lag 0 in the same cycle that ch3 commits frame 5. Result is frame 4's data. The next-cycle lag-0 read returns frame 5.
- Assert clr with 3 reads in flight. All 3 return their pre-clr results. fill=0, and any lag then misses until a frame commits. Separately, pulse rst_n low mid-write: all outputs are 0 immediately.

Source files
------------

// File: rtl/mic_frame_ring.sv
// Multi-channel circular sample buffer: packs interleaved samples into CH-wide frames, keeps the newest 2^ADDR_W-1 frames.
// Lag-addressed reads return after a fixed 2 cycles; neither path has backpressure, and out-of-order samples are flagged and dropped.
module mic_frame_ring #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10,
  parameter int CH     = 4,
  localparam int CH_W  = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              frame_tick,
  output logic              seq_err,
  output logic [ADDR_W-1:0] fill,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_lag,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_miss
);

  localparam int                DEPTH    = 1 << (ADDR_W + CH_W);
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;
  localparam logic [CH_W-1:0]   LAST_CH  = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_slot_q, wr_slot_d;
  logic [CH_W-1:0]   exp_ch_q, exp_ch_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              tick_q, tick_d;
  logic              err_q, err_d;
  logic              we;

  logic [ADDR_W+CH_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]      rd_slot;
  logic                   s1_vld_q, s1_miss_q;
  logic                   s2_vld_q, s2_miss_q;
  logic [DATA_W-1:0]      ram_q;
  logic                   rd_valid_q, rd_miss_q;
  logic [DATA_W-1:0]      rd_data_q;

  always_comb begin
    wr_slot_d = wr_slot_q;
    exp_ch_d  = exp_ch_q;
    fill_d    = fill_q;
    tick_d    = 1'b0;
    err_d     = 1'b0;
    we        = 1'b0;
    if (clr) begin
      wr_slot_d = '0;
      exp_ch_d  = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      if (in_ch == exp_ch_q) begin
        we = 1'b1;
        if (in_ch == LAST_CH) begin
          wr_slot_d = wr_slot_q + ADDR_W'(1);
          exp_ch_d  = '0;
          tick_d    = 1'b1;
          if (fill_q != FILL_MAX) fill_d = fill_q + ADDR_W'(1);
        end else begin
          exp_ch_d = exp_ch_q + CH_W'(1);
        end
      end else begin
        // A stray channel 0 is taken as the start of a fresh frame rather than lost.
        err_d = 1'b1;
        if (in_ch == '0) begin
          we       = 1'b1;
          exp_ch_d = CH_W'(1);
        end else begin
          exp_ch_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_slot_q <= '0;
      exp_ch_q  <= '0;
      fill_q    <= '0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_slot_q <= wr_slot_d;
      exp_ch_q  <= exp_ch_d;
      fill_q    <= fill_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[{wr_slot_q, in_ch}] <= in_data;
  end

  // Lag 0 is the slot just behind the in-progress one, using pre-commit state.
  always_comb begin
    rd_slot   = wr_slot_q - ADDR_W'(1) - rd_lag;
    rd_addr_d = rd_req ? {rd_slot, rd_ch} : rd_addr_q;
  end

  always_ff @(posedge clk) begin
    ram_q <= mem_q[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_miss_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_miss_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      s1_vld_q   <= rd_req;
      s1_miss_q  <= rd_req && (rd_lag >= fill_q);
      s2_vld_q   <= s1_vld_q;
      s2_miss_q  <= s1_miss_q;
      rd_valid_q <= s2_vld_q;
      rd_miss_q  <= s2_vld_q && s2_miss_q;
      rd_data_q  <= (s2_vld_q && !s2_miss_q) ? ram_q : '0;
    end
  end

  assign frame_tick = tick_q;
  assign seq_err    = err_q;
  assign fill       = fill_q;
  assign rd_valid   = rd_valid_q;
  assign rd_miss    = rd_miss_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_mic_frame_ring.sv
// Directed bench for mic_frame_ring (CH=4, ADDR_W=4): read expectations queued at issue, checked by a monitor on rd_valid.
module tb_mic_frame_ring;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ch = '0;
  logic [17:0] in_data = '0;
  logic        frame_tick, seq_err;
  logic [3:0]  fill;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [3:0]  rd_lag = '0;
  logic        rd_valid, rd_miss;
  logic [17:0] rd_data;

  mic_frame_ring #(.DATA_W(18), .ADDR_W(4), .CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .frame_tick(frame_tick), .seq_err(seq_err), .fill(fill),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_lag(rd_lag),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_miss(rd_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [17:0] data;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_tick = 0;
  int   n_err = 0;
  int   tag_n = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_tick) n_tick++;
      if (seq_err) n_err++;
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: rd_valid with miss=%0b data=%0d but no read outstanding", rd_miss, rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (rd_miss !== mon_e.miss || rd_data !== mon_e.data) begin
            errors++;
            $display("FAIL read#%0d: got miss=%0b data=%0d, expected miss=%0b data=%0d",
                     mon_e.tag, rd_miss, rd_data, mon_e.miss, mon_e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic cyc(input logic iv, input int ich, input int idat,
                     input logic rq, input int rch, input int rlag,
                     input logic emiss, input int edat, input logic cl);
    exp_t e2;
    in_valid = iv;
    in_ch    = ich[1:0];
    in_data  = idat[17:0];
    rd_req   = rq;
    rd_ch    = rch[1:0];
    rd_lag   = rlag[3:0];
    clr      = cl;
    if (rq) begin
      e2.miss = emiss;
      e2.data = emiss ? 18'd0 : edat[17:0];
      e2.tag  = tag_n;
      tag_n++;
      exp_q.push_back(e2);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rd_req   = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send(input int ch, input int d);
    cyc(1'b1, ch, d, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int ch, input int lag, input logic miss, input int d);
    cyc(1'b0, 0, 0, 1'b1, ch, lag, miss, d, 1'b0);
  endtask

  task automatic send_frame(input int base);
    for (int c = 0; c < 4; c++) send(c, base + c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d reads still outstanding, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_frame_tick", int'(frame_tick), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_miss", int'(rd_miss), 0);

    // Three frames, sample = 16*frame + ch
    for (int f = 0; f < 3; f++) send_frame(16 * f);
    idle(1);
    chk("fill_3", int'(fill), 3);
    chk("ticks_3", n_tick, 3);
    rd(2, 0, 1'b0, 34);
    rd(1, 2, 1'b0, 1);
    rd(0, 3, 1'b1, 0);
    drain("basic");

    // Twenty frames total: fill saturates, oldest visible is frame 5
    for (int f = 3; f < 20; f++) send_frame(16 * f);
    idle(1);
    chk("fill_sat", int'(fill), 15);
    chk("ticks_20", n_tick, 20);
    rd(3, 14, 1'b0, 83);
    rd(3, 15, 1'b1, 0);
    rd(0, 0, 1'b0, 304);
    drain("wrap");

    // Skipped channel 2: broken frame dropped
    send(0, 90); send(1, 91); send(3, 93);
    send_frame(100);
    idle(1);
    chk("seq_err_skip", n_err, 1);
    chk("ticks_skip", n_tick, 21);
    chk("fill_skip", int'(fill), 15);
    rd(3, 0, 1'b0, 103);
    rd(0, 0, 1'b0, 100);
    rd(3, 1, 1'b0, 307);
    drain("skip");

    // Restart on channel 0: second ch0 begins the committed frame
    send(0, 110); send(1, 111); send(0, 120); send(1, 121); send(2, 122); send(3, 123);
    idle(1);
    chk("seq_err_restart", n_err, 2);
    chk("ticks_restart", n_tick, 22);
    rd(0, 0, 1'b0, 120);
    rd(1, 0, 1'b0, 121);
    rd(3, 1, 1'b0, 103);
    drain("restart");

    // Read in the commit cycle sees the previous frame
    send(0, 200); send(1, 201); send(2, 202);
    cyc(1'b1, 3, 203, 1'b1, 3, 0, 1'b0, 123, 1'b0);
    rd(3, 0, 1'b0, 203);
    idle(1);
    chk("ticks_same", n_tick, 23);
    drain("same_cycle");

    // clr with three reads in flight and a would-be commit in the clr cycle
    send(0, 250); send(1, 251); send(2, 252);
    rd(0, 0, 1'b0, 200);
    rd(1, 1, 1'b0, 121);
    cyc(1'b1, 3, 253, 1'b1, 2, 2, 1'b0, 102, 1'b1);
    chk("fill_clr", int'(fill), 0);
    rd(0, 0, 1'b1, 0);
    rd(3, 14, 1'b1, 0);
    idle(2);
    chk("ticks_clr", n_tick, 23);
    chk("seq_err_clr", n_err, 2);
    send_frame(300);
    idle(1);
    chk("fill_after_clr", int'(fill), 1);
    chk("ticks_after_clr", n_tick, 24);
    rd(2, 0, 1'b0, 302);
    rd(2, 1, 1'b1, 0);
    drain("clr");

    // Async reset with a commit and a read result both live
    send(0, 400);
    cyc(1'b1, 1, 401, 1'b1, 0, 0, 1'b0, 300, 1'b0);
    send(2, 402);
    send(3, 403);
    chk("pre_rst_tick", int'(frame_tick), 1);
    chk("pre_rst_valid", int'(rd_valid), 1);
    chk("pre_rst_fill", int'(fill), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_frame_tick", int'(frame_tick), 0);
    chk("arst_seq_err", int'(seq_err), 0);
    chk("arst_fill", int'(fill), 0);
    chk("arst_rd_valid", int'(rd_valid), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_rd_miss", int'(rd_miss), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_fill", int'(fill), 0);
    rd(1, 0, 1'b1, 0);
    send_frame(500);
    rd(1, 0, 1'b0, 501);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
